tl_rr_arbiter: RTL and testbench

- N-to-1 round-robin arbiter sharing one downstream valid/ready channel among N requesters (e.g. TileLink hosts feeding a shared fifo_sync).
- Packet-aware: once a multi-beat packet starts, the grant is locked to that requester until its last beat is accepted.
- Zero-latency combinational data path; arbitration state is registered.

---
 rtl/tl_rr_arbiter.sv | 119 +++++++++++
 tb/tb_tl_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tl_rr_arbiter
// Brief    : Packet-aware N-to-1 round-robin arbiter onto one valid/ready
//            channel; combinational data path, registered arbitration state.
// Revision : 1.0 - initial release
// ============================================================================
module tl_rr_arbiter #(
    parameter int N                = 4,
    parameter int Width            = 32,
    parameter int IdxW             = 3,
    parameter bit OutputZeroIfIdle = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic [N-1:0]         req_valid_i,
    output logic [N-1:0]         req_ready_o,
    input  logic [N*Width-1:0]   req_data_i,
    input  logic [N-1:0]         req_last_i,
    output logic                 gnt_valid_o,
    input  logic                 gnt_ready_i,
    output logic [Width-1:0]     gnt_data_o,
    output logic                 gnt_last_o,
    output logic [IdxW-1:0]      gnt_idx_o,
    output logic                 busy_o
);

    localparam logic [IdxW-1:0] c_last_idx = IdxW'(N - 1);

    logic [IdxW-1:0]  r_prio_ptr;
    logic             r_locked;
    logic [IdxW-1:0]  r_lock_idx;

    logic [IdxW-1:0]  w_sel;
    logic             w_found;
    logic             w_active;
    logic             w_sel_valid;
    logic [Width-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_gnt_valid;
    logic             w_acc;

    // Two-pass search: indices at/above the pointer first, then wrap to the
    // lowest valid index overall.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        if (r_locked) begin
            w_sel   = r_lock_idx;
            w_found = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && req_valid_i[i] && (IdxW'(i) >= r_prio_ptr)) begin
                    w_sel   = IdxW'(i);
                    w_found = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!w_found && req_valid_i[i]) begin
                    w_sel   = IdxW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == IdxW'(i)) begin
                w_sel_valid = req_valid_i[i];
                w_sel_data  = req_data_i[i*Width +: Width];
                w_sel_last  = req_last_i[i];
            end
        end
    end

    assign w_active    = r_locked | w_found;
    assign w_gnt_valid = w_active & w_sel_valid;
    assign w_acc       = w_gnt_valid & gnt_ready_i;

    assign gnt_valid_o = w_gnt_valid;
    assign gnt_data_o  = (OutputZeroIfIdle && !w_gnt_valid) ? '0 : w_sel_data;
    assign gnt_last_o  = (OutputZeroIfIdle && !w_gnt_valid) ? 1'b0 : w_sel_last;
    assign gnt_idx_o   = w_sel;
    assign busy_o      = r_locked;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready_o[gi] = gnt_ready_i & w_gnt_valid & (w_sel == IdxW'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prio_ptr <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (clr_i) begin
            r_prio_ptr <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_acc) begin
            if (w_sel_last) begin
                r_locked   <= 1'b0;
                r_prio_ptr <= (w_sel == c_last_idx) ? '0 : w_sel + IdxW'(1);
            end else begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tl_rr_arbiter
// Brief    : Scoreboard bench for tl_rr_arbiter with a queue-free pointer/lock
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              clr_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*W-1:0]    req_data_i;
    logic [N-1:0]      req_last_i;
    logic              gnt_valid_o;
    logic              gnt_ready_i;
    logic [W-1:0]      gnt_data_o;
    logic              gnt_last_o;
    logic [IW-1:0]     gnt_idx_o;
    logic              busy_o;

    tl_rr_arbiter #(.N(N), .Width(W), .IdxW(IW), .OutputZeroIfIdle(1'b1)) dut (
        .clock       (clock),
        .reset       (reset),
        .clr_i       (clr_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .gnt_data_o  (gnt_data_o),
        .gnt_last_o  (gnt_last_o),
        .gnt_idx_o   (gnt_idx_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] idx;
        logic [W-1:0]  d;
        logic          l;
        logic [N-1:0]  rdy;
        logic          busy;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: priority pointer and the owner of an open packet (-1 = none).
    int         m_ptr  = 0;
    int         m_lock = -1;
    logic [N-1:0] cur_v, cur_l;
    logic [W-1:0] cur_d [N];

    function automatic int pick();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++) begin
            if (cur_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock of stimulus; returns the index whose beat was accepted (-1 if none).
    task automatic step(input logic rst_n, input logic rdy, input logic clr, output int acc);
        int   s;
        exp_t e;
        reset       = rst_n;
        clr_i       = clr;
        gnt_ready_i = rdy;
        req_valid_i = cur_v;
        req_last_i  = cur_l;
        for (int i = 0; i < N; i++) req_data_i[i*W +: W] = cur_d[i];
        if (!rst_n) begin
            m_ptr  = 0;
            m_lock = -1;
        end
        s      = pick();
        e      = '0;
        e.busy = (m_lock >= 0);
        if (s >= 0) begin
            e.idx = IW'(s);
            e.v   = cur_v[s];
            if (e.v) begin
                e.d = cur_d[s];
                e.l = cur_l[s];
                if (rdy) e.rdy = N'(1) << s;
            end
        end
        sb.push_back(e);
        acc = (e.v && rdy) ? s : -1;
        @(posedge clock);
        if (rst_n) begin
            if (clr) begin
                m_ptr  = 0;
                m_lock = -1;
            end else if (acc >= 0) begin
                if (cur_l[acc]) begin
                    m_lock = -1;
                    m_ptr  = (acc + 1) % N;
                end else begin
                    m_lock = acc;
                end
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic l);
        cur_v[i] = v;
        cur_d[i] = d;
        cur_l[i] = l;
    endtask

    always @(negedge clock) begin
        exp_t e, a;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {gnt_valid_o, gnt_idx_o, gnt_data_o, gnt_last_o, req_ready_o, busy_o};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL grant@cyc%0d: got v=%b idx=%0d d=%h l=%b rdy=%b busy=%b, want v=%b idx=%0d d=%h l=%b rdy=%b busy=%b",
                         cyc, a.v, a.idx, a.d, a.l, a.rdy, a.busy, e.v, e.idx, e.d, e.l, e.rdy, e.busy);
            end
        end
    end

    initial begin
        int acc;
        reset       = 1'b0;
        clr_i       = 1'b0;
        gnt_ready_i = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        cur_v       = '0;
        cur_l       = '0;
        for (int i = 0; i < N; i++) cur_d[i] = '0;
        @(posedge clock);
        #1;

        // Reset state with nothing requesting
        step(1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, acc);

        // All requesters, single-beat packets: grants rotate 0,1,2,3,0
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h1000_0000 + i, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b0, acc);
            if (acc >= 0) cur_d[acc] = cur_d[acc] + 32'h10;
        end

        // Requester 1 sends a 3-beat packet while 0 and 2 stay valid
        set_req(3, 1'b0, '0, 1'b1);
        set_req(0, 1'b1, 32'hA0A0_0000, 1'b1);
        set_req(2, 1'b1, 32'hC2C2_0000, 1'b0);
        for (int b = 0; b < 3; b++) begin
            set_req(1, 1'b1, 32'hB1B1_0000 + b, (b == 2));
            step(1'b1, 1'b1, 1'b0, acc);
        end
        set_req(1, 1'b0, '0, 1'b0);

        // Locked on 2 (first beat not last), then 2 drops valid for two cycles
        step(1'b1, 1'b1, 1'b0, acc);
        set_req(2, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, acc);
        set_req(2, 1'b1, 32'hC2C2_0001, 1'b1);
        step(1'b1, 1'b1, 1'b0, acc);
        set_req(2, 1'b0, '0, 1'b0);
        set_req(0, 1'b0, '0, 1'b0);

        // Backpressure: requester 3 held for 4 cycles, then accepted
        set_req(3, 1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, acc);
        set_req(3, 1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of a packet
        set_req(1, 1'b1, 32'h1111_0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, acc);
        cur_v = '0;
        step(1'b0, 1'b1, 1'b0, acc);
        set_req(2, 1'b1, 32'h2222_0000, 1'b0);
        set_req(3, 1'b1, 32'h3333_0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, acc);

        // Synchronous clear in the middle of a packet, with a beat on offer
        set_req(2, 1'b1, 32'h2222_0001, 1'b0);
        step(1'b1, 1'b1, 1'b1, acc);
        set_req(0, 1'b1, 32'h0000_0ABC, 1'b1);
        step(1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, acc);

        // Randomized traffic obeying the hold-until-accepted rule
        cur_v = '0;
        for (int c = 0; c < 2000; c++) begin
            logic rdy, clr, rst_n;
            rdy   = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            if (!rst_n) cur_v = '0;
            step(rst_n, rdy, clr, acc);
            for (int i = 0; i < N; i++) begin
                if (i == acc) begin
                    cur_v[i] = $urandom_range(0, 1);
                    cur_d[i] = $urandom;
                    cur_l[i] = ($urandom_range(0, 2) == 0);
                end else if (!cur_v[i] && ($urandom_range(0, 9) < 4)) begin
                    cur_v[i] = 1'b1;
                    cur_d[i] = $urandom;
                    cur_l[i] = ($urandom_range(0, 2) == 0);
                end
            end
        end

        @(negedge clock);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
